// File: rtl/caxi4interconnect_fifo_pkg.sv
// Shared sizing helpers and configuration limits for the crossbar flip-flop FIFOs.
package caxi4interconnect_fifo_pkg;

  localparam int unsigned FIFO_AWIDTH_MIN = 1;
  localparam int unsigned FIFO_AWIDTH_MAX = 9;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned ram_depth(input int unsigned awidth);
    return 32'd1 << awidth;
  endfunction

  // The HI_FREQ output register holds one entry on top of the RAM.
  function automatic int unsigned fifo_capacity(input int unsigned awidth,
                                                input int unsigned hi_freq);
    return ram_depth(awidth) + ((hi_freq != 0) ? 32'd1 : 32'd0);
  endfunction

  function automatic bit depth_ok(input int unsigned awidth);
    return (awidth >= FIFO_AWIDTH_MIN) && (awidth <= FIFO_AWIDTH_MAX);
  endfunction

endpackage

// File: rtl/caxi4interconnect_ff_ram_2p.sv
// Two-port register-file storage: synchronous write, asynchronous or registered read.
module caxi4interconnect_ff_ram_2p
  import caxi4interconnect_fifo_pkg::*;
#(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned REG_RD = 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  (* syn_ramstyle = "registers" *) logic [WIDTH-1:0] mem_q [ram_depth(AWIDTH)];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  if (REG_RD != 0) begin : g_reg_rd
    logic [WIDTH-1:0] rdata_q;

    // Holds the last issued word while re_i is low; same-address write returns old data.
    always_ff @(posedge clk_i) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
  end else begin : g_async_rd
    logic unused_re;

    assign unused_re = re_i;
    assign rdata_o   = mem_q[raddr_i];
  end

endmodule

// File: rtl/caxi4interconnect_ff_sync_fifo.sv
// Synchronous FWFT FIFO with valid/ready ports, occupancy count, level flags and flush.
module caxi4interconnect_ff_sync_fifo
  import caxi4interconnect_fifo_pkg::*;
#(
  parameter int unsigned FIFO_AWIDTH  = 4,
  parameter int unsigned FIFO_WIDTH   = 8,
  parameter int unsigned HI_FREQ      = 1,
  parameter int unsigned AFULL_LEVEL  = (2 ** FIFO_AWIDTH) - 1,
  parameter int unsigned AEMPTY_LEVEL = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic [FIFO_AWIDTH:0]  fifo_count,
  output logic                  fifo_afull,
  output logic                  fifo_aempty
);

  localparam int unsigned CW  = FIFO_AWIDTH + 1;
  localparam int unsigned CAP = fifo_capacity(FIFO_AWIDTH, HI_FREQ);
  localparam bit          HF  = (HI_FREQ != 0);

  localparam logic [CW-1:0] CAP_C    = CW'(CAP);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

  if (!depth_ok(FIFO_AWIDTH) || (AFULL_LEVEL > CAP) || (clog2(CAP + 1) > CW)) begin : g_bad_cfg
    $error("caxi4interconnect_ff_sync_fifo: illegal FIFO_AWIDTH or AFULL_LEVEL");
  end

  logic [FIFO_AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          ram_cnt_q, ram_cnt_d;
  logic                   pend_q, pend_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [FIFO_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   wr_ready_q, wr_ready_d;
  logic                   afull_q, afull_d;
  logic                   aempty_q, aempty_d;

  logic                  push, pop, out_load, issue, rd_adv;
  logic [FIFO_WIDTH-1:0] ram_rdata;

  // HI_FREQ: ram_cnt counts words not yet issued; pend marks a word held in the RAM read register.
  always_comb begin
    push     = wr_valid && wr_ready_q;
    pop      = rd_valid_q && rd_ready;
    out_load = HF && pend_q && (!rd_valid_q || pop);
    issue    = HF && (ram_cnt_q != '0) && (!pend_q || out_load);
    rd_adv   = HF ? issue : pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ram_cnt_d  = ram_cnt_q;
    pend_d     = issue || (pend_q && !out_load);
    out_data_d = out_load ? ram_rdata : out_data_q;

    if (push)   wr_ptr_d = wr_ptr_q + FIFO_AWIDTH'(1);
    if (rd_adv) rd_ptr_d = rd_ptr_q + FIFO_AWIDTH'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case ({push, rd_adv})
      2'b10:   ram_cnt_d = ram_cnt_q + CW'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - CW'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ram_cnt_d  = '0;
      pend_d     = 1'b0;
      out_data_d = '0;
    end

    rd_valid_d = HF ? (out_load || (rd_valid_q && !pop)) : (count_d != '0);
    if (flush) rd_valid_d = 1'b0;

    wr_ready_d = (count_d != CAP_C);
    afull_d    = (count_d >= AFULL_C);
    aempty_d   = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ram_cnt_q  <= '0;
      pend_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      out_data_q <= '0;
      wr_ready_q <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ram_cnt_q  <= ram_cnt_d;
      pend_q     <= pend_d;
      rd_valid_q <= rd_valid_d;
      out_data_q <= out_data_d;
      wr_ready_q <= wr_ready_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
    end
  end

  caxi4interconnect_ff_ram_2p #(
    .AWIDTH (FIFO_AWIDTH),
    .WIDTH  (FIFO_WIDTH),
    .REG_RD (HI_FREQ)
  ) u_ram (
    .clk_i   (HCLK),
    .we_i    (push && !flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (issue && !flush),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign wr_ready    = wr_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = HF ? out_data_q : ram_rdata;
  assign fifo_count  = count_q;
  assign fifo_afull  = afull_q;
  assign fifo_aempty = aempty_q;

endmodule

// File: tb/tb_caxi4interconnect_ff_sync_fifo.sv
// Directed bench for caxi4interconnect_ff_sync_fifo, run once per HI_FREQ setting.
module tb_caxi4interconnect_ff_sync_fifo;

  logic       HCLK = 1'b0;
  logic       HRESETn, flush, wr_valid, rd_ready;
  logic [7:0] wr_data;
  logic       hf;

  logic       wr_ready_0, wr_ready_1, rd_valid_0, rd_valid_1;
  logic       afull_0, afull_1, aempty_0, aempty_1;
  logic [7:0] rd_data_0, rd_data_1;
  logic [2:0] fifo_count_0, fifo_count_1;

  logic       wr_ready, rd_valid, fifo_afull, fifo_aempty;
  logic [7:0] rd_data;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  assign wr_ready    = hf ? wr_ready_1   : wr_ready_0;
  assign rd_valid    = hf ? rd_valid_1   : rd_valid_0;
  assign rd_data     = hf ? rd_data_1    : rd_data_0;
  assign fifo_count  = hf ? fifo_count_1 : fifo_count_0;
  assign fifo_afull  = hf ? afull_1      : afull_0;
  assign fifo_aempty = hf ? aempty_1     : aempty_0;

  caxi4interconnect_ff_sync_fifo #(
    .FIFO_AWIDTH (2), .FIFO_WIDTH (8), .HI_FREQ (0)
  ) dut_lo (
    .HCLK (HCLK), .HRESETn (HRESETn), .flush (flush),
    .wr_valid (wr_valid), .wr_ready (wr_ready_0), .wr_data (wr_data),
    .rd_valid (rd_valid_0), .rd_ready (rd_ready), .rd_data (rd_data_0),
    .fifo_count (fifo_count_0), .fifo_afull (afull_0), .fifo_aempty (aempty_0)
  );

  caxi4interconnect_ff_sync_fifo #(
    .FIFO_AWIDTH (2), .FIFO_WIDTH (8), .HI_FREQ (1)
  ) dut_hi (
    .HCLK (HCLK), .HRESETn (HRESETn), .flush (flush),
    .wr_valid (wr_valid), .wr_ready (wr_ready_1), .wr_data (wr_data),
    .rd_valid (rd_valid_1), .rd_ready (rd_ready), .rd_data (rd_data_1),
    .fifo_count (fifo_count_1), .fifo_afull (afull_1), .fifo_aempty (aempty_1)
  );

  task automatic do_reset();
    HRESETn = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 8'h00;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid hf=%0d got=%b want=0", hf, rd_valid); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready hf=%0d got=%b want=1", hf, wr_ready); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count hf=%0d got=%0d want=0", hf, fifo_count); end
    checks++; if (fifo_afull !== 1'b0) begin failures++; $display("FAIL reset_afull hf=%0d got=%b want=0", hf, fifo_afull); end
    checks++; if (fifo_aempty !== 1'b1) begin failures++; $display("FAIL reset_aempty hf=%0d got=%b want=1", hf, fifo_aempty); end
    if (hf) begin
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data hf=%0d got=%h want=00", hf, rd_data); end
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] pat [5];
    int cap;
    pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    cap = 4 + int'(hf);
    for (int i = 0; i < cap; i++) begin
      wr_valid = 1'b1; wr_data = pat[i];
      @(posedge HCLK); #1;
    end
    wr_valid = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_wr_ready hf=%0d got=%b want=0", hf, wr_ready); end
    checks++; if (fifo_count !== 3'(cap)) begin failures++; $display("FAIL full_count hf=%0d got=%0d want=%0d", hf, fifo_count, cap); end
    checks++; if (fifo_afull !== 1'b1) begin failures++; $display("FAIL full_afull hf=%0d got=%b want=1", hf, fifo_afull); end
    checks++; if (fifo_aempty !== 1'b0) begin failures++; $display("FAIL full_aempty hf=%0d got=%b want=0", hf, fifo_aempty); end
    rd_ready = 1'b1;
    for (int i = 0; i < cap; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== pat[i]) begin
        failures++; $display("FAIL drain_data hf=%0d idx=%0d got=%b/%h want=1/%h", hf, i, rd_valid, rd_data, pat[i]);
      end
      @(posedge HCLK); #1;
    end
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL drained_rd_valid hf=%0d got=%b want=0", hf, rd_valid); end
    checks++; if (fifo_aempty !== 1'b1) begin failures++; $display("FAIL drained_aempty hf=%0d got=%b want=1", hf, fifo_aempty); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL drained_count hf=%0d got=%0d want=0", hf, fifo_count); end
  endtask

  // Latency = edges after the push edge before rd_valid is seen (0 async read, 2 registered read).
  task automatic test_latency();
    int lat, exp_lat;
    exp_lat = hf ? 2 : 0;
    wr_valid = 1'b1; wr_data = 8'hA5;
    @(posedge HCLK); #1;
    wr_valid = 1'b0;
    lat = 0;
    while (rd_valid !== 1'b1 && lat < 8) begin
      @(posedge HCLK); #1;
      lat++;
    end
    checks++; if (lat != exp_lat) begin failures++; $display("FAIL latency hf=%0d got=%0d want=%0d", hf, lat, exp_lat); end
    checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL latency_data hf=%0d got=%h want=a5", hf, rd_data); end
    rd_ready = 1'b1;
    @(posedge HCLK); #1;
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL latency_pop hf=%0d got=%b want=0", hf, rd_valid); end
  endtask

  // Registered read keeps up to three words in flight (RAM, read register, output stage).
  task automatic test_streaming();
    int sent, recv, cyc, bound;
    bit started, push_now, pop_now;
    bound = hf ? 3 : 2;
    sent = 0; recv = 0; cyc = 0; started = 1'b0;
    rd_ready = 1'b1;
    while (recv < 20 && cyc < 60) begin
      wr_valid = (sent < 20);
      wr_data  = 8'(sent);
      if (rd_valid === 1'b1) started = 1'b1;
      if (started) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'(recv)) begin
          failures++; $display("FAIL stream_data hf=%0d idx=%0d got=%b/%h want=1/%h", hf, recv, rd_valid, rd_data, 8'(recv));
        end
      end
      checks++; if (fifo_count > 3'(bound)) begin failures++; $display("FAIL stream_count hf=%0d got=%0d want<=%0d", hf, fifo_count, bound); end
      push_now = wr_valid && wr_ready;
      pop_now  = rd_valid && rd_ready;
      @(posedge HCLK); #1;
      if (push_now) sent++;
      if (pop_now) recv++;
      cyc++;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    checks++; if (recv != 20) begin failures++; $display("FAIL stream_timeout hf=%0d got=%0d want=20", hf, recv); end
    checks++; if (cyc > 20 + 3) begin failures++; $display("FAIL stream_cycles hf=%0d got=%0d want<=23", hf, cyc); end
  endtask

  task automatic test_full_pop();
    int cap;
    logic [7:0] exp;
    cap = 4 + int'(hf);
    for (int i = 0; i < cap; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h60 + i);
      @(posedge HCLK); #1;
    end
    wr_data = 8'h99; rd_ready = 1'b1;
    checks++; if (wr_ready !== 1'b0 || fifo_count !== 3'(cap)) begin failures++; $display("FAIL fp_full hf=%0d got=%b/%0d want=0/%0d", hf, wr_ready, fifo_count, cap); end
    @(posedge HCLK); #1;
    checks++; if (fifo_count !== 3'(cap - 1)) begin failures++; $display("FAIL fp_pop_count hf=%0d got=%0d want=%0d", hf, fifo_count, cap - 1); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL fp_wr_ready_rise hf=%0d got=%b want=1", hf, wr_ready); end
    rd_ready = 1'b0;
    @(posedge HCLK); #1;
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 3'(cap) || wr_ready !== 1'b0) begin failures++; $display("FAIL fp_refill hf=%0d got=%0d/%b want=%0d/0", hf, fifo_count, wr_ready, cap); end
    rd_ready = 1'b1;
    for (int i = 0; i < cap; i++) begin
      exp = (i < cap - 1) ? 8'(8'h61 + i) : 8'h99;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        failures++; $display("FAIL fp_drain hf=%0d idx=%0d got=%b/%h want=1/%h", hf, i, rd_valid, rd_data, exp);
      end
      @(posedge HCLK); #1;
    end
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL fp_empty hf=%0d got=%b want=0", hf, rd_valid); end
  endtask

  task automatic test_flush();
    int n;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h71 + i);
      @(posedge HCLK); #1;
    end
    wr_data = 8'hEE; flush = 1'b1;
    @(posedge HCLK); #1;
    flush = 1'b0; wr_valid = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL flush_count hf=%0d got=%0d want=0", hf, fifo_count); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL flush_rd_valid hf=%0d got=%b want=0", hf, rd_valid); end
    checks++; if (wr_ready !== 1'b1 || fifo_aempty !== 1'b1 || fifo_afull !== 1'b0) begin
      failures++; $display("FAIL flush_flags hf=%0d got=%b%b%b want=110", hf, wr_ready, fifo_aempty, fifo_afull);
    end
    wr_valid = 1'b1; wr_data = 8'h3C;
    @(posedge HCLK); #1;
    wr_valid = 1'b0;
    n = 0;
    while (rd_valid !== 1'b1 && n < 8) begin @(posedge HCLK); #1; n++; end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin failures++; $display("FAIL flush_next_data hf=%0d got=%b/%h want=1/3c", hf, rd_valid, rd_data); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL flush_next_count hf=%0d got=%0d want=1", hf, fifo_count); end
    rd_ready = 1'b1;
    @(posedge HCLK); #1;
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL flush_stale hf=%0d got=%b/%h want=0", hf, rd_valid, rd_data); end
  endtask

  task automatic test_async_reset();
    int n;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h81 + i);
      @(posedge HCLK); #1;
    end
    #2 HRESETn = 1'b0;
    #1;
    wr_valid = 1'b0;
    checks++; if (rd_valid !== 1'b0 || wr_ready !== 1'b1) begin failures++; $display("FAIL arst_hs hf=%0d got=%b/%b want=0/1", hf, rd_valid, wr_ready); end
    checks++; if (fifo_count !== 3'd0 || fifo_afull !== 1'b0 || fifo_aempty !== 1'b1) begin
      failures++; $display("FAIL arst_count hf=%0d got=%0d/%b/%b want=0/0/1", hf, fifo_count, fifo_afull, fifo_aempty);
    end
    if (hf) begin
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL arst_rd_data hf=%0d got=%h want=00", hf, rd_data); end
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h5A;
    @(posedge HCLK); #1;
    wr_valid = 1'b0;
    n = 0;
    while (rd_valid !== 1'b1 && n < 8) begin @(posedge HCLK); #1; n++; end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin failures++; $display("FAIL arst_data hf=%0d got=%b/%h want=1/5a", hf, rd_valid, rd_data); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL arst_next_count hf=%0d got=%0d want=1", hf, fifo_count); end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      hf = m[0];
      do_reset();
      test_reset();
      test_fill_drain();
      test_latency();
      test_streaming();
      test_full_pop();
      test_flush();
      test_async_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
